// File: rtl/uart_tx_engine.sv
// UART transmit path: TX FIFO plus LCR-formatted serialiser; start bit one cycle after a push is visible.
// Pushes into a full FIFO are dropped; a stalled tx_enable freezes the frame in place.
module uart_tx_engine #(
    parameter int DEPTH         = 16,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       tx_fifo_we,
    input  logic [7:0] PWDATA,
    input  logic       tx_fifo_clr,
    input  logic       tx_enable,
    input  logic [7:0] LCR,
    output logic [4:0] tx_fifo_count,
    output logic       tx_fifo_empty,
    output logic       tx_fifo_full,
    output logic       tx_busy,
    output logic       TXD
);
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_W   = 5'(DEPTH);
    localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [3:0]    lcr_l;
    logic          par_bit, stop2, line;

    logic          bit_end, last_stop, pop, push_ok, head_par;
    logic [7:0]    head, head_mask;
    logic [4:0]    count_nxt;
    logic          unused_lcr7;

    assign unused_lcr7 = LCR[7];

    function automatic logic drv(input logic brk, input logic v);
        return brk ? 1'b0 : v;
    endfunction

    always_comb begin
        bit_end   = tx_enable && (tick_cnt == LAST_TICK);
        last_stop = !lcr_l[2] || stop2;
        pop       = (tx_fifo_count != 5'd0) &&
                    ((state == IDLE) || (state == STOP && bit_end && last_stop));
        push_ok   = tx_fifo_we && !tx_fifo_full;
        head      = mem[rd_ptr];
        case (LCR[1:0])
            2'd0:    head_mask = 8'h1F;
            2'd1:    head_mask = 8'h3F;
            2'd2:    head_mask = 8'h7F;
            default: head_mask = 8'hFF;
        endcase
        // Parity is resolved at the pop so only the latched frame settings matter later.
        if (LCR[5])
            head_par = ~LCR[4];
        else if (LCR[4])
            head_par = ^(head & head_mask);
        else
            head_par = ~^(head & head_mask);
        if (tx_fifo_clr)
            count_nxt = 5'd0;
        else
            count_nxt = tx_fifo_count + {4'd0, push_ok} - {4'd0, pop};
    end

    always_ff @(posedge PCLK) begin
        if (push_ok && !tx_fifo_clr)
            mem[wr_ptr] <= PWDATA;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            tx_fifo_count <= 5'd0;
            tx_fifo_empty <= 1'b1;
            tx_fifo_full  <= 1'b0;
        end else begin
            if (tx_fifo_clr) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
            end
            tx_fifo_count <= count_nxt;
            tx_fifo_empty <= (count_nxt == 5'd0);
            tx_fifo_full  <= (count_nxt == DEPTH_W);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            lcr_l    <= 4'd0;
            par_bit  <= 1'b0;
            stop2    <= 1'b0;
            line     <= 1'b1;
            TXD      <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            // Break overrides the line level without disturbing the frame underneath.
            TXD <= drv(LCR[6], line);
            if (pop) begin
                state    <= START;
                shift    <= head;
                lcr_l    <= LCR[3:0];
                par_bit  <= head_par;
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
                stop2    <= 1'b0;
                line     <= 1'b0;
                TXD      <= 1'b0;
                tx_busy  <= 1'b1;
            end else if (state != IDLE && tx_enable) begin
                if (!bit_end) begin
                    tick_cnt <= tick_cnt + 4'd1;
                end else begin
                    tick_cnt <= 4'd0;
                    case (state)
                        START: begin
                            state <= DATA;
                            line  <= shift[0];
                            TXD   <= drv(LCR[6], shift[0]);
                        end
                        DATA: begin
                            if (bit_cnt == {1'b0, lcr_l[1:0]} + 3'd4) begin
                                if (lcr_l[3]) begin
                                    state <= PARITY;
                                    line  <= par_bit;
                                    TXD   <= drv(LCR[6], par_bit);
                                end else begin
                                    state <= STOP;
                                    line  <= 1'b1;
                                    TXD   <= drv(LCR[6], 1'b1);
                                end
                            end else begin
                                shift   <= {1'b0, shift[7:1]};
                                bit_cnt <= bit_cnt + 3'd1;
                                line    <= shift[1];
                                TXD     <= drv(LCR[6], shift[1]);
                            end
                        end
                        PARITY: begin
                            state <= STOP;
                            line  <= 1'b1;
                            TXD   <= drv(LCR[6], 1'b1);
                        end
                        STOP: begin
                            if (!last_stop) begin
                                stop2 <= 1'b1;
                            end else begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frame shapes, parity modes, FIFO limits, break and reset.
module tb_uart_tx_engine;
    logic       PCLK        = 1'b0;
    logic       PRESETn     = 1'b0;
    logic       tx_fifo_we  = 1'b0;
    logic [7:0] PWDATA      = 8'h00;
    logic       tx_fifo_clr = 1'b0;
    logic       tx_enable   = 1'b0;
    logic [7:0] LCR         = 8'h03;
    logic [4:0] tx_fifo_count;
    logic       tx_fifo_empty, tx_fifo_full, tx_busy, TXD;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 PCLK = ~PCLK;

    uart_tx_engine #(.DEPTH(16), .TICKS_PER_BIT(16)) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .tx_fifo_we    (tx_fifo_we),
        .PWDATA        (PWDATA),
        .tx_fifo_clr   (tx_fifo_clr),
        .tx_enable     (tx_enable),
        .LCR           (LCR),
        .tx_fifo_count (tx_fifo_count),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_full  (tx_fifo_full),
        .tx_busy       (tx_busy),
        .TXD           (TXD)
    );

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        PWDATA     = d;
        tx_fifo_we = 1'b1;
        step(1);
        tx_fifo_we = 1'b0;
    endtask

    // bits[0] is the first bit on the wire; each bit is sampled on all 16 cycles.
    // A break window of 20 cycles starts after sample brk_at (negative = none).
    task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits,
                               input int brk_at);
        logic exp_b;
        for (int i = 0; i < nbits * 16; i++) begin
            exp_b = (brk_at >= 0 && i > brk_at && i <= brk_at + 20) ? 1'b0 : bits[i / 16];
            chk($sformatf("%s txd s%0d", tag, i), {31'd0, TXD}, {31'd0, exp_b});
            chk($sformatf("%s busy s%0d", tag, i), {31'd0, tx_busy}, 32'd1);
            if (i == brk_at)      LCR[6] = 1'b1;
            if (i == brk_at + 20) LCR[6] = 1'b0;
            step(1);
        end
    endtask

    task automatic send_frame(input string tag, input logic [7:0] lcr, input logic [7:0] d,
                              input logic [11:0] bits, input int nbits, input int brk_at);
        LCR = lcr;
        push(d);
        step(1);
        check_frame(tag, bits, nbits, brk_at);
        chk({tag, " end busy"}, {31'd0, tx_busy}, 32'd0);
        chk({tag, " end txd"}, {31'd0, TXD}, 32'd1);
    endtask

    initial begin
        // Reset state
        step(2);
        chk("rst txd",   {31'd0, TXD},           32'd1);
        chk("rst busy",  {31'd0, tx_busy},       32'd0);
        chk("rst count", {27'd0, tx_fifo_count}, 32'd0);
        chk("rst empty", {31'd0, tx_fifo_empty}, 32'd1);
        chk("rst full",  {31'd0, tx_fifo_full},  32'd0);
        PRESETn = 1'b1;
        step(1);

        // 8N1 0x55 with status timing around the pop
        tx_enable = 1'b1;
        LCR = 8'h03;
        push(8'h55);
        chk("push count", {27'd0, tx_fifo_count}, 32'd1);
        chk("push empty", {31'd0, tx_fifo_empty}, 32'd0);
        chk("push txd",   {31'd0, TXD},           32'd1);
        chk("push busy",  {31'd0, tx_busy},       32'd0);
        step(1);
        chk("pop count", {27'd0, tx_fifo_count}, 32'd0);
        chk("pop empty", {31'd0, tx_fifo_empty}, 32'd1);
        check_frame("8N1_55", {2'b11, 1'b1, 8'h55, 1'b0}, 10, -1);
        chk("8N1 end busy", {31'd0, tx_busy}, 32'd0);
        chk("8N1 end txd",  {31'd0, TXD},     32'd1);

        // Parity modes on 0x07 (three ones)
        send_frame("8E1_07",   8'h1B, 8'h07, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1);
        send_frame("8O1_07",   8'h0B, 8'h07, {1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1);
        send_frame("stick_07", 8'h2B, 8'h07, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1);

        // 5 data bits, 2 stop bits: 128 cycles, upper bits never sent
        send_frame("5N2_FF", 8'h04, 8'hFF, {4'hF, 1'b1, 1'b1, 5'h1F, 1'b0}, 8, -1);

        // Break for 20 cycles in the middle of a frame
        send_frame("brk_C3", 8'h03, 8'hC3, {2'b11, 1'b1, 8'hC3, 1'b0}, 10, 40);

        // Fill while the serialiser is stalled in a start bit
        LCR = 8'h03;
        tx_enable = 1'b0;
        push(8'hFF);
        for (int d = 0; d <= 16; d++) push(8'(d));
        chk("fill count", {27'd0, tx_fifo_count}, 32'd16);
        chk("fill full",  {31'd0, tx_fifo_full},  32'd1);
        chk("fill empty", {31'd0, tx_fifo_empty}, 32'd0);
        chk("fill busy",  {31'd0, tx_busy},       32'd1);
        chk("fill txd",   {31'd0, TXD},           32'd0);
        tx_enable = 1'b1;
        check_frame("fill_FF", {2'b11, 1'b1, 8'hFF, 1'b0}, 10, -1);
        for (int d = 0; d < 16; d++)
            check_frame($sformatf("b2b_%0d", d), {2'b11, 1'b1, 8'(d), 1'b0}, 10, -1);
        chk("drain busy",  {31'd0, tx_busy},       32'd0);
        chk("drain empty", {31'd0, tx_fifo_empty}, 32'd1);
        chk("drain txd",   {31'd0, TXD},           32'd1);

        // Push and pop in the same cycle at count 3, then flush with a colliding push
        tx_enable = 1'b0;
        push(8'h81);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("pp pre count", {27'd0, tx_fifo_count}, 32'd3);
        tx_enable = 1'b1;
        step(159);
        chk("pp stop txd",   {31'd0, TXD},           32'd1);
        chk("pp stop count", {27'd0, tx_fifo_count}, 32'd3);
        push(8'h44);
        chk("pp count", {27'd0, tx_fifo_count}, 32'd3);
        chk("pp txd",   {31'd0, TXD},           32'd0);
        chk("pp busy",  {31'd0, tx_busy},       32'd1);
        tx_fifo_clr = 1'b1;
        PWDATA      = 8'h5A;
        tx_fifo_we  = 1'b1;
        step(1);
        tx_fifo_clr = 1'b0;
        tx_fifo_we  = 1'b0;
        chk("clr count", {27'd0, tx_fifo_count}, 32'd0);
        chk("clr empty", {31'd0, tx_fifo_empty}, 32'd1);
        chk("clr busy",  {31'd0, tx_busy},       32'd1);
        chk("clr txd",   {31'd0, TXD},           32'd0);
        step(170);
        chk("clr done busy",  {31'd0, tx_busy},       32'd0);
        chk("clr done txd",   {31'd0, TXD},           32'd1);
        chk("clr done count", {27'd0, tx_fifo_count}, 32'd0);

        // Reset during the data bits of 0xA5 with another byte queued
        LCR = 8'h03;
        push(8'hA5);
        push(8'h5A);
        step(40);
        chk("mid txd",   {31'd0, TXD},           32'd0);
        chk("mid count", {27'd0, tx_fifo_count}, 32'd1);
        PRESETn = 1'b0;
        #1;
        chk("arst txd",   {31'd0, TXD},           32'd1);
        chk("arst count", {27'd0, tx_fifo_count}, 32'd0);
        chk("arst busy",  {31'd0, tx_busy},       32'd0);
        chk("arst empty", {31'd0, tx_fifo_empty}, 32'd1);
        step(1);
        PRESETn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            chk($sformatf("post txd c%0d", i),  {31'd0, TXD},     32'd1);
            chk($sformatf("post busy c%0d", i), {31'd0, tx_busy}, 32'd0);
            step(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
